// File: rtl/mel_filter_bank.sv
// mel_filter_bank: half-overlapping rectangular MEL bands accumulated over one frame of FFT magnitude bins.
// Build option MEL_SAT_EN: band accumulators saturate at all-ones instead of wrapping.
module mel_filter_bank #(
  parameter int N_FFT         = 256,
  parameter int N_MEL         = 32,
  parameter int DATAIN_WIDTH  = 15,
  parameter int DATAOUT_WIDTH = 16,
  parameter int BIN_W         = $clog2(N_FFT/2)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_sync,
  input  logic                        data_in_valid,
  input  logic                        data_in_sof,
  input  logic [DATAIN_WIDTH-1:0]     data_in,
  input  logic                        edge_wr_en,
  input  logic [$clog2(N_MEL+2)-1:0]  edge_wr_addr,
  input  logic [BIN_W-1:0]            edge_wr_data,
  output logic                        mel_valid,
  output logic [$clog2(N_MEL)-1:0]    mel_idx,
  output logic [DATAOUT_WIDTH-1:0]    mel_value,
  output logic                        frame_done,
  output logic                        frame_abort,
  output logic                        cfg_err
);

  localparam int N_BIN  = N_FFT / 2;
  localparam int N_EDGE = N_MEL + 2;
  localparam int EA_W   = $clog2(N_EDGE);
  localparam int IDX_W  = $clog2(N_MEL);
  localparam int STEP   = N_BIN / N_EDGE;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [N_EDGE-1:0][BIN_W-1:0] edge_tbl_t;
  typedef struct packed {
    logic                     last;
    logic [DATAOUT_WIDTH-1:0] acc;
  } lane_t;

  state_t                   state_q, state_d;
  logic [BIN_W-1:0]         bin_cnt_q, bin_cnt_d;
  logic [EA_W-1:0]          band_a_q, band_a_d, band_b_q, band_b_d;
  logic [DATAOUT_WIDTH-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  edge_tbl_t                shadow_q, shadow_d, active_q, active_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     mel_valid_q, mel_valid_d;
  logic [IDX_W-1:0]         mel_idx_q, mel_idx_d;
  logic [DATAOUT_WIDTH-1:0] mel_value_q, mel_value_d;
  logic                     frame_done_q, frame_done_d;
  logic                     frame_abort_q, frame_abort_d;

  edge_tbl_t                tbl;
  logic                     err;
  logic [BIN_W-1:0]         bin;
  logic [EA_W-1:0]          band_a, band_b;
  logic [DATAOUT_WIDTH-1:0] acc_a_in, acc_b_in;
  lane_t                    lane_a, lane_b;
  logic                     sof_go, beat_go;

  function automatic logic [DATAOUT_WIDTH-1:0] acc_add(input logic [DATAOUT_WIDTH-1:0] acc,
                                                       input logic [DATAIN_WIDTH-1:0]  din);
`ifdef MEL_SAT_EN
    logic [DATAOUT_WIDTH:0] sum;
    sum = {1'b0, acc} + {1'b0, DATAOUT_WIDTH'(din)};
    return sum[DATAOUT_WIDTH] ? '1 : sum[DATAOUT_WIDTH-1:0];
`else
    return acc + DATAOUT_WIDTH'(din);
`endif
  endfunction

  function automatic logic table_ok(input edge_tbl_t t);
    logic ok;
    ok = 1'b1;
    for (int k = 1; k < N_EDGE; k++) begin
      if (t[k] <= t[k-1]) ok = 1'b0;
    end
    return ok;
  endfunction

  // One accumulator lane: band m spans E[m] .. E[m+2]-1; once past the last band it stays idle.
  function automatic lane_t lane_step(input logic [EA_W-1:0]          band,
                                      input logic [BIN_W-1:0]         b,
                                      input logic [DATAOUT_WIDTH-1:0] acc,
                                      input logic [DATAIN_WIDTH-1:0]  din,
                                      input edge_tbl_t                t);
    lane_t            res;
    logic             live;
    logic [EA_W-1:0]  lo, hi;
    logic [BIN_W-1:0] start, stop;
    live  = band < EA_W'(N_MEL);
    lo    = live ? band : '0;
    hi    = live ? EA_W'(band + EA_W'(2)) : EA_W'(N_EDGE - 1);
    start = t[lo];
    stop  = BIN_W'(t[hi] - 1'b1);
    res.acc  = acc;
    res.last = 1'b0;
    if (live && b >= start && b <= stop) begin
      res.acc  = (b == start) ? DATAOUT_WIDTH'(din) : acc_add(acc, din);
      res.last = (b == stop);
    end
    return res;
  endfunction

  // A sof beat copies the shadow table first, so that very beat is binned with the new edges.
  always_comb begin
    state_d       = state_q;
    bin_cnt_d     = bin_cnt_q;
    band_a_d      = band_a_q;
    band_b_d      = band_b_q;
    acc_a_d       = acc_a_q;
    acc_b_d       = acc_b_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    cfg_err_d     = cfg_err_q;
    mel_valid_d   = 1'b0;
    mel_idx_d     = mel_idx_q;
    mel_value_d   = mel_value_q;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;

    sof_go  = en_sync && data_in_valid && data_in_sof;
    beat_go = en_sync && data_in_valid && (data_in_sof || state_q == RUN);

    tbl      = active_q;
    err      = cfg_err_q;
    bin      = bin_cnt_q;
    band_a   = band_a_q;
    band_b   = band_b_q;
    acc_a_in = acc_a_q;
    acc_b_in = acc_b_q;

    if (edge_wr_en && edge_wr_addr <= EA_W'(N_EDGE - 1)) begin
      shadow_d[edge_wr_addr] = edge_wr_data;
    end

    if (sof_go) begin
      tbl           = shadow_q;
      err           = !table_ok(shadow_q);
      active_d      = shadow_q;
      cfg_err_d     = err;
      bin           = '0;
      band_a        = '0;
      band_b        = EA_W'(1);
      acc_a_in      = '0;
      acc_b_in      = '0;
      frame_abort_d = (state_q == RUN);
    end

    lane_a = lane_step(band_a, bin, acc_a_in, data_in, tbl);
    lane_b = lane_step(band_b, bin, acc_b_in, data_in, tbl);

    if (beat_go) begin
      acc_a_d   = lane_a.acc;
      acc_b_d   = lane_b.acc;
      band_a_d  = lane_a.last ? EA_W'(band_a + EA_W'(2)) : band_a;
      band_b_d  = lane_b.last ? EA_W'(band_b + EA_W'(2)) : band_b;
      bin_cnt_d = BIN_W'(bin + 1'b1);
      // Strictly increasing edges never close both lanes on one bin; the A-first order only matters for bad tables, whose output is suppressed.
      if (!err && lane_a.last) begin
        mel_valid_d = 1'b1;
        mel_idx_d   = band_a[IDX_W-1:0];
        mel_value_d = lane_a.acc;
      end else if (!err && lane_b.last) begin
        mel_valid_d = 1'b1;
        mel_idx_d   = band_b[IDX_W-1:0];
        mel_value_d = lane_b.acc;
      end
      if (bin == BIN_W'(N_BIN - 1)) begin
        state_d      = DONE;
        frame_done_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end

    if (!en_sync) begin
      state_d       = IDLE;
      bin_cnt_d     = '0;
      band_a_d      = '0;
      band_b_d      = EA_W'(1);
      acc_a_d       = '0;
      acc_b_d       = '0;
      mel_valid_d   = 1'b0;
      frame_done_d  = 1'b0;
      frame_abort_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bin_cnt_q     <= '0;
      band_a_q      <= '0;
      band_b_q      <= EA_W'(1);
      acc_a_q       <= '0;
      acc_b_q       <= '0;
      cfg_err_q     <= 1'b0;
      mel_valid_q   <= 1'b0;
      mel_idx_q     <= '0;
      mel_value_q   <= '0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      for (int k = 0; k < N_EDGE; k++) begin
        shadow_q[k] <= BIN_W'(k * STEP);
        active_q[k] <= BIN_W'(k * STEP);
      end
    end else begin
      state_q       <= state_d;
      bin_cnt_q     <= bin_cnt_d;
      band_a_q      <= band_a_d;
      band_b_q      <= band_b_d;
      acc_a_q       <= acc_a_d;
      acc_b_q       <= acc_b_d;
      cfg_err_q     <= cfg_err_d;
      mel_valid_q   <= mel_valid_d;
      mel_idx_q     <= mel_idx_d;
      mel_value_q   <= mel_value_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  assign mel_valid   = mel_valid_q;
  assign mel_idx     = mel_idx_q;
  assign mel_value   = mel_value_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_mel_filter_bank.sv
// tb_mel_filter_bank: directed, table-driven bench for mel_filter_bank with default parameters.
// Expected band sums are hand-derived from the default edge table E[k]=3k.
module tb_mel_filter_bank;

  localparam int N_MEL = 32;
  localparam int N_BIN = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_sync;
  logic        data_in_valid;
  logic        data_in_sof;
  logic [14:0] data_in;
  logic        edge_wr_en;
  logic [5:0]  edge_wr_addr;
  logic [6:0]  edge_wr_data;
  logic        mel_valid;
  logic [4:0]  mel_idx;
  logic [15:0] mel_value;
  logic        frame_done;
  logic        frame_abort;
  logic        cfg_err;

  mel_filter_bank dut (
    .clk           (clk),
    .rst           (rst),
    .en_sync       (en_sync),
    .data_in_valid (data_in_valid),
    .data_in_sof   (data_in_sof),
    .data_in       (data_in),
    .edge_wr_en    (edge_wr_en),
    .edge_wr_addr  (edge_wr_addr),
    .edge_wr_data  (edge_wr_data),
    .mel_valid     (mel_valid),
    .mel_idx       (mel_idx),
    .mel_value     (mel_value),
    .frame_done    (frame_done),
    .frame_abort   (frame_abort),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     mon_idx[$];
  int     mon_val[$];
  longint mon_t[$];
  int     done_cnt = 0;
  int     abort_cnt = 0;
  longint done_t = 0;
  longint abort_t = 0;
  longint beat_t[N_BIN];
  int     m0, d0, a0;

  // Output monitor samples on the falling edge, half a cycle after the registers update.
  always @(negedge clk) begin
    if (mel_valid) begin
      mon_idx.push_back(int'(mel_idx));
      mon_val.push_back(int'(mel_value));
      mon_t.push_back($time);
    end
    if (frame_done) begin
      done_cnt++;
      done_t = $time;
    end
    if (frame_abort) begin
      abort_cnt++;
      abort_t = $time;
    end
  end

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic s, input logic [14:0] d,
                                input logic we, input int wa, input int wd);
    @(negedge clk);
    data_in_valid = v;
    data_in_sof   = s;
    data_in       = d;
    edge_wr_en    = we;
    edge_wr_addr  = 6'(wa);
    edge_wr_data  = 7'(wd);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 1'b0, 15'd0, 1'b0, 0, 0);
  endtask

  task automatic write_edge(input int addr, input int val);
    apply_stimulus(1'b0, 1'b0, 15'd0, 1'b1, addr, val);
    idle(1);
  endtask

  task automatic mark();
    m0 = mon_idx.size();
    d0 = done_cnt;
    a0 = abort_cnt;
  endtask

  // Bins 0..nbins-1 with sof on bin 0, optional random gaps and one edge write on bin wr_bin.
  task automatic send_frame(input int val, input int nbins, input int max_gap,
                            input int wr_bin, input int wr_addr, input int wr_data);
    for (int b = 0; b < nbins; b++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        apply_stimulus(1'b0, 1'($urandom), 15'($urandom), 1'b0, 0, 0);
      end
      apply_stimulus(1'b1, b == 0, 15'(val), b == wr_bin, wr_addr, wr_data);
      beat_t[b] = $time;
    end
  endtask

  // Default edges: band m closes on bin 3m+5, so its strobe lands one cycle after that beat.
  task automatic check_bands(input string tag, input int base, input int exp_val, input bit chk_lat);
    for (int m = 0; m < N_MEL && m0 + base + m < mon_idx.size(); m++) begin
      check_output($sformatf("%s band%0d idx", tag, m), mon_idx[m0 + base + m], m);
      check_output($sformatf("%s band%0d value", tag, m), mon_val[m0 + base + m], exp_val);
      if (chk_lat) begin
        check_output($sformatf("%s band%0d time", tag, m), mon_t[m0 + base + m], beat_t[3 * m + 5] + 10);
      end
    end
  endtask

  typedef struct {
    int val;
    int max_gap;
    int exp_val;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   sat0, sat1, sat2;

    vecs[0] = '{val: 1, max_gap: 0, exp_val: 6};
    vecs[1] = '{val: 1, max_gap: 3, exp_val: 6};
    vecs[2] = '{val: 5, max_gap: 2, exp_val: 30};
    vecs[3] = '{val: 0, max_gap: 1, exp_val: 0};
`ifdef MEL_SAT_EN
    vecs[4] = '{val: 'h3000, max_gap: 0, exp_val: 'hFFFF};
    sat0 = 'hFFFF; sat1 = 'hFFFF; sat2 = 'hFFFF;
`else
    vecs[4] = '{val: 'h3000, max_gap: 0, exp_val: 'h2000};
    sat0 = 'hFFF6; sat1 = 'hFFF8; sat2 = 'hFFFE;
`endif

    rst = 1'b1; en_sync = 1'b0; data_in_valid = 1'b0; data_in_sof = 1'b0; data_in = '0;
    edge_wr_en = 1'b0; edge_wr_addr = '0; edge_wr_data = '0;
    idle(3);
    check_output("reset mel_valid", mel_valid, 0);
    check_output("reset mel_idx", mel_idx, 0);
    check_output("reset mel_value", mel_value, 0);
    check_output("reset frame_done", frame_done, 0);
    check_output("reset frame_abort", frame_abort, 0);
    check_output("reset cfg_err", cfg_err, 0);
    rst = 1'b0;
    en_sync = 1'b1;
    idle(2);

    $display("[TB] beats without sof in IDLE are dropped");
    mark();
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 15'd1, 1'b0, 0, 0);
    idle(3);
    check_output("idle no-sof outputs", mon_idx.size() - m0, 0);
    check_output("idle no-sof done", done_cnt - d0, 0);

    $display("[TB] table-driven frames with default edges");
    for (int i = 0; i < 5; i++) begin
      mark();
      send_frame(vecs[i].val, N_BIN, vecs[i].max_gap, -1, 0, 0);
      idle(4);
      check_output($sformatf("v%0d count", i), mon_idx.size() - m0, N_MEL);
      check_bands($sformatf("v%0d", i), 0, vecs[i].exp_val, 1'b1);
      check_output($sformatf("v%0d done count", i), done_cnt - d0, 1);
      check_output($sformatf("v%0d done time", i), done_t, beat_t[N_BIN-1] + 10);
      check_output($sformatf("v%0d abort count", i), abort_cnt - a0, 0);
    end

    $display("[TB] back-to-back frames");
    mark();
    send_frame(1, N_BIN, 0, -1, 0, 0);
    send_frame(2, N_BIN, 0, -1, 0, 0);
    idle(4);
    check_output("b2b count", mon_idx.size() - m0, 2 * N_MEL);
    check_bands("b2b f0", 0, 6, 1'b0);
    check_bands("b2b f1", N_MEL, 12, 1'b1);
    check_output("b2b done count", done_cnt - d0, 2);
    check_output("b2b done time", done_t, beat_t[N_BIN-1] + 10);
    check_output("b2b abort count", abort_cnt - a0, 0);

    $display("[TB] shadow edge write mid-frame");
    mark();
    send_frame(1, N_BIN, 0, 50, 1, 1);
    idle(4);
    check_output("shadow cur count", mon_idx.size() - m0, N_MEL);
    if (mon_idx.size() - m0 >= 2) check_output("shadow cur band1", mon_val[m0 + 1], 6);
    mark();
    send_frame(1, N_BIN, 0, -1, 0, 0);
    idle(4);
    check_output("shadow next count", mon_idx.size() - m0, N_MEL);
    if (mon_idx.size() - m0 >= 3) begin
      check_output("shadow next band0", mon_val[m0], 6);
      check_output("shadow next band1", mon_val[m0 + 1], 8);
      check_output("shadow next band2", mon_val[m0 + 2], 6);
    end
    check_output("shadow next cfg_err", cfg_err, 0);
    write_edge(1, 3);

    $display("[TB] non-increasing edge table");
    write_edge(5, 12);
    check_output("cfg_err before sof", cfg_err, 0);
    mark();
    send_frame(1, N_BIN, 0, -1, 0, 0);
    idle(4);
    check_output("cfg_err set", cfg_err, 1);
    check_output("cfg_err no mel", mon_idx.size() - m0, 0);
    check_output("cfg_err done count", done_cnt - d0, 1);
    write_edge(5, 15);
    check_output("cfg_err sticky", cfg_err, 1);
    mark();
    send_frame(1, N_BIN, 0, -1, 0, 0);
    idle(4);
    check_output("cfg_err cleared", cfg_err, 0);
    check_output("cfg_err recover count", mon_idx.size() - m0, N_MEL);

    $display("[TB] sof at bin 40 aborts the running frame");
    mark();
    send_frame(1, 40, 0, -1, 0, 0);
    send_frame(1, N_BIN, 0, -1, 0, 0);
    idle(4);
    check_output("abort count", abort_cnt - a0, 1);
    check_output("abort time", abort_t, beat_t[0] + 10);
    check_output("abort mel count", mon_idx.size() - m0, 12 + N_MEL);
    check_bands("abort new", 12, 6, 1'b1);
    check_output("abort done count", done_cnt - d0, 1);

    $display("[TB] en_sync dropped mid-frame");
    mark();
    send_frame(1, 60, 0, -1, 0, 0);
    idle(1);
    en_sync = 1'b0;
    apply_stimulus(1'b1, 1'b1, 15'd1, 1'b0, 0, 0);
    apply_stimulus(1'b1, 1'b0, 15'd1, 1'b0, 0, 0);
    idle(2);
    en_sync = 1'b1;
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 15'd1, 1'b0, 0, 0);
    idle(3);
    check_output("en drop partial count", mon_idx.size() - m0, 19);
    check_output("en drop done", done_cnt - d0, 0);
    send_frame(1, N_BIN, 0, -1, 0, 0);
    idle(4);
    check_output("en drop total count", mon_idx.size() - m0, 19 + N_MEL);
    check_bands("en restart", 19, 6, 1'b1);
    check_output("en drop abort", abort_cnt - a0, 0);
    check_output("en restart done", done_cnt - d0, 1);

    $display("[TB] full-scale bins with E[2]=10, E[3]=11");
    write_edge(2, 10);
    write_edge(3, 11);
    mark();
    send_frame('h7FFF, N_BIN, 0, -1, 0, 0);
    idle(4);
    check_output("sat cfg_err", cfg_err, 0);
    check_output("sat count", mon_idx.size() - m0, N_MEL);
    if (mon_idx.size() - m0 >= 3) begin
      check_output("sat band0 idx", mon_idx[m0], 0);
      check_output("sat band0 value", mon_val[m0], sat0);
      check_output("sat band0 time", mon_t[m0], beat_t[9] + 10);
      check_output("sat band1 value", mon_val[m0 + 1], sat1);
      check_output("sat band2 value", mon_val[m0 + 2], sat2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
